// File: rtl/r_inst_fetch.sv
// r_inst_fetch: instruction fetch stage feeding the R-type decode datapath.
// Holds the PC, reads a 1-cycle-latency synchronous ROM and hands one
// instruction at a time to decode over valid/ready. Stops on HALT_WORD and
// resumes only on reset or redirect.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt outputs.
module r_inst_fetch #(
    parameter int unsigned          ADDR_W    = 6,
    parameter int unsigned          DATA_W    = 32,
    parameter logic [31:0]          RESET_PC  = 32'h0000_0000,
    parameter logic [DATA_W-1:0]    HALT_WORD = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_en,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [31:0]       inst_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_OUT   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [31:0]       inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;

    // Low PC bits of the redirect target are architecturally ignored.
    logic redirect_pc_unused;
    assign redirect_pc_unused = ^redirect_pc[1:0];

    assign imem_addr  = pc_q[ADDR_W+1:2];
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign halted     = halted_q;

    // Next-state, datapath updates and ROM enable; redirect overrides the handshake.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        imem_en   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_en = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                inst_d    = imem_rdata;
                inst_pc_d = pc_q;
                pc_d      = pc_q + 32'd4;
                valid_d   = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (inst_ready) begin
                    valid_d = 1'b0;
                    if (inst_q == HALT_WORD) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        imem_en = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase

        if (redirect_en) begin
            pc_d      = {redirect_pc[31:2], 2'b00};
            inst_d    = inst_q;
            inst_pc_d = inst_pc_q;
            valid_d   = 1'b0;
            halted_d  = 1'b0;
            state_d   = S_FETCH;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;

    // Saturating counts of accepted instructions and backpressured cycles.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (valid_q && inst_ready && !redirect_en && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (valid_q && !inst_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_r_inst_fetch.sv
// Directed self-checking bench for r_inst_fetch with a behavioural 1-cycle ROM.
module tb_r_inst_fetch;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_en;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [31:0]       inst_pc;
    logic              halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       fetch_cnt;
    logic [31:0]       stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];

    r_inst_fetch #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RESET_PC(32'h0000_0000),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, data valid the cycle after the enable.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom[imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (imem_en !== 1'b1) begin n_fail++; $display("FAIL rst_imem_en got %b exp 1", imem_en); end
        n_cmp++; if (imem_addr !== 6'd0) begin n_fail++; $display("FAIL rst_imem_addr got %0d exp 0", imem_addr); end
        n_cmp++; if ({inst_valid, halted} !== 2'b00) begin n_fail++; $display("FAIL rst_valid_halted got %b exp 00", {inst_valid, halted}); end
        n_cmp++; if ({inst, inst_pc} !== 64'd0) begin n_fail++; $display("FAIL rst_inst got %h/%h exp 0/0", inst, inst_pc); end
        tick();
        n_cmp++; if ({inst_valid, imem_en} !== 2'b00) begin n_fail++; $display("FAIL rst_wait got %b exp 00", {inst_valid, imem_en}); end
        tick();
        n_cmp++; if ({inst_valid, halted} !== 2'b10) begin n_fail++; $display("FAIL rst_first_out got %b exp 10", {inst_valid, halted}); end
        n_cmp++; if (inst !== 32'd1 || inst_pc !== 32'd0) begin n_fail++; $display("FAIL rst_first_inst got %h/%h exp 1/0", inst, inst_pc); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_inst [5];
        exp_inst = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FFFF};
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_gap%0d got %b exp 0", k, inst_valid); end
            tick();
            n_cmp++; if (inst_valid !== 1'b1 || inst !== exp_inst[k] || inst_pc !== 32'(4*k))
                begin n_fail++; $display("FAIL stream_inst%0d got %b %h/%h exp 1 %h/%h", k, inst_valid, inst, inst_pc, exp_inst[k], 32'(4*k)); end
        end
        n_cmp++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL stream_halt_noread got %b exp 0", imem_en); end
        tick();
        n_cmp++; if ({halted, inst_valid} !== 2'b10) begin n_fail++; $display("FAIL stream_halted got %b exp 10", {halted, inst_valid}); end
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if ({imem_en, halted} !== 2'b01) begin n_fail++; $display("FAIL halt_hold%0d got %b exp 01", c, {imem_en, halted}); end
            tick();
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 1'b1;
        tick(); tick();
        tick();
        inst_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'd2 || inst_pc !== 32'd4 || imem_en !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold%0d got %b %h/%h en %b exp 1 2/4 en 0", c, inst_valid, inst, inst_pc, imem_en); end
            tick();
        end
        inst_ready = 1'b1;
        #1;
        n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 6'd2) begin n_fail++; $display("FAIL bp_release got en %b addr %0d exp 1 2", imem_en, imem_addr); end
        tick(); tick();
        n_cmp++; if (inst !== 32'd3 || inst_pc !== 32'd8) begin n_fail++; $display("FAIL bp_next got %h/%h exp 3/8", inst, inst_pc); end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        inst_ready = 1'b1;
        tick();
        redirect_en = 1'b1; redirect_pc = 32'h23;
        tick();
        redirect_en = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 6'd8)
            begin n_fail++; $display("FAIL redir_wait got v %b en %b addr %0d exp 0 1 8", inst_valid, imem_en, imem_addr); end
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale got %b exp 0", inst_valid); end
        tick();
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'hA0A0_0008 || inst_pc !== 32'h20)
            begin n_fail++; $display("FAIL redir_target got %b %h/%h exp 1 a0a00008/20", inst_valid, inst, inst_pc); end
        redirect_en = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect_en = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || imem_addr !== 6'd1) begin n_fail++; $display("FAIL redir_drop got v %b addr %0d exp 0 1", inst_valid, imem_addr); end
        tick(); tick();
        n_cmp++; if (inst !== 32'd2 || inst_pc !== 32'd4) begin n_fail++; $display("FAIL redir_out got %h/%h exp 2/4", inst, inst_pc); end
        inst_ready = 1'b0;
    endtask

    task automatic test_halt_redirect();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin tick(); tick(); end
        tick();
        tick();
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hr_halted got %b exp 1", halted); end
        redirect_en = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_en = 1'b0;
        n_cmp++; if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 6'd0)
            begin n_fail++; $display("FAIL hr_resume got h %b en %b addr %0d exp 0 1 0", halted, imem_en, imem_addr); end
        tick(); tick();
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'd1 || inst_pc !== 32'd0)
            begin n_fail++; $display("FAIL hr_first got %b %h/%h exp 1 1/0", inst_valid, inst, inst_pc); end
        inst_ready = 1'b0;
        tick(); tick();
        rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40;
        tick();
        rst = 1'b0; redirect_en = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || imem_addr !== 6'd0 || inst !== 32'd0 || inst_pc !== 32'd0)
            begin n_fail++; $display("FAIL rst_vs_redir got v %b addr %0d %h/%h exp 0 0 0/0", inst_valid, imem_addr, inst, inst_pc); end
        tick(); tick();
        n_cmp++; if (inst !== 32'd1 || inst_pc !== 32'd0) begin n_fail++; $display("FAIL rst_vs_redir_pc got %h/%h exp 1/0", inst, inst_pc); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        n_cmp++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_reset got %0d/%0d exp 0/0", fetch_cnt, stall_cnt); end
        tick(); tick();
        tick(); tick(); tick();
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin tick(); tick(); end
        tick();
        tick(); tick();
        n_cmp++; if (fetch_cnt !== 32'd5 || stall_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_counts got %0d/%0d exp 5/3", fetch_cnt, stall_cnt); end
        do_reset();
        n_cmp++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_clear got %0d/%0d exp 0/0", fetch_cnt, stall_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 4; i++) rom[i] = 32'(i + 1);
        rom[4] = 32'hFFFF_FFFF;
        rom[8] = 32'hA0A0_0008;
        imem_rdata = '0;
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt_redirect();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
